// File: rtl/argmax_classifier_if.sv
// Handshake bundle between layer 5, the argmax classifier and the result consumer.
// The slave side is the classifier; the master side is whoever drives frames and accepts results.
interface argmax_classifier_if #(
    parameter int NUM_CLASS = 10,
    parameter int DW        = 32,
    parameter int CW        = 4
);
    logic                      valid_i;
    logic [NUM_CLASS*DW-1:0]   logits_i;
    logic                      busy_o;
    logic                      valid_o;
    logic                      ready_i;
    logic [CW-1:0]             class_o;
    logic [DW-1:0]             max_o;
    logic [15:0]               img_cnt_o;
    logic                      drop_o;

    modport master (
        output valid_i, logits_i, ready_i,
        input  busy_o, valid_o, class_o, max_o, img_cnt_o, drop_o
    );

    modport slave (
        input  valid_i, logits_i, ready_i,
        output busy_o, valid_o, class_o, max_o, img_cnt_o, drop_o
    );
endinterface

// File: rtl/argmax_classifier.sv
// Final MNIST stage: captures one frame of signed logits, scans them one per cycle for the
// largest value (lowest index wins ties) and offers the winning class on a valid/ready port.
module argmax_classifier #(
    parameter int NUM_CLASS = 10,
    parameter int DW        = 32,
    parameter int CW        = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    argmax_classifier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                         state_reg, state_next;
    logic [NUM_CLASS-1:0][DW-1:0]   frame_reg;
    logic signed [DW-1:0]           best_val_reg, best_val_next;
    logic [CW-1:0]                  best_idx_reg, best_idx_next;
    logic [CW-1:0]                  idx_reg, idx_next;
    logic                           valid_reg, valid_next;
    logic                           busy_reg;
    logic                           drop_reg, drop_next;
    logic [15:0]                    img_cnt_reg, img_cnt_next;
    logic                           capture;
    logic                           handshake;

    assign handshake = valid_reg & bus.ready_i;

    always_comb begin
        state_next    = state_reg;
        best_val_next = best_val_reg;
        best_idx_next = best_idx_reg;
        idx_next      = idx_reg;
        valid_next    = 1'b0;
        drop_next     = drop_reg;
        img_cnt_next  = img_cnt_reg;
        capture       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.valid_i) begin
                    capture = 1'b1;
                end
            end
            SCAN: begin
                if ($signed(frame_reg[idx_reg]) > best_val_reg) begin
                    best_val_next = $signed(frame_reg[idx_reg]);
                    best_idx_next = idx_reg;
                end
                idx_next = idx_reg + CW'(1);
                if (idx_reg == CW'(NUM_CLASS - 1)) begin
                    state_next = DONE;
                end
                if (bus.valid_i) begin
                    drop_next = 1'b1;
                end
            end
            DONE: begin
                // valid_o trails the state by one cycle, so the result is offered
                // until the cycle in which the consumer takes it.
                if (handshake) begin
                    img_cnt_next = img_cnt_reg + 16'd1;
                    state_next   = IDLE;
                    if (bus.valid_i) begin
                        capture = 1'b1;
                    end
                end else begin
                    valid_next = 1'b1;
                    if (bus.valid_i) begin
                        drop_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            state_next    = SCAN;
            best_val_next = $signed(bus.logits_i[DW-1:0]);
            best_idx_next = '0;
            idx_next      = CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            frame_reg    <= '0;
            best_val_reg <= '0;
            best_idx_reg <= '0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            drop_reg     <= 1'b0;
            img_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            best_val_reg <= best_val_next;
            best_idx_reg <= best_idx_next;
            idx_reg      <= idx_next;
            valid_reg    <= valid_next;
            busy_reg     <= (state_reg != IDLE);
            drop_reg     <= drop_next;
            img_cnt_reg  <= img_cnt_next;
            if (capture) begin
                frame_reg <= bus.logits_i;
            end
        end
    end

    assign bus.valid_o   = valid_reg;
    assign bus.busy_o    = busy_reg;
    assign bus.class_o   = best_idx_reg;
    assign bus.max_o     = best_val_reg;
    assign bus.img_cnt_o = img_cnt_reg;
    assign bus.drop_o    = drop_reg;
endmodule

// File: tb/tb_argmax_classifier.sv
// Directed and randomized frames for argmax_classifier; expected winners are queued when a
// frame is driven and compared when the classifier offers its result.
module tb_argmax_classifier;
    localparam int NC = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    argmax_classifier_if #(.NUM_CLASS(NC), .DW(32), .CW(4)) bus ();

    argmax_classifier #(.NUM_CLASS(NC), .DW(32), .CW(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  cls;
        logic [31:0] mx;
    } exp_t;

    exp_t                sb[$];
    int                  checks   = 0;
    int                  failures = 0;
    logic [15:0]         exp_cnt  = 16'd0;
    logic                exp_drop = 1'b0;
    logic signed [31:0]  lg [NC];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [NC*32-1:0] pack_lg();
        logic [NC*32-1:0] v;
        for (int k = 0; k < NC; k++) v[32*k +: 32] = lg[k];
        return v;
    endfunction

    // Reference argmax: strictly greater replaces, so ties keep the lowest index.
    function automatic exp_t model();
        exp_t e;
        logic signed [31:0] best;
        best  = lg[0];
        e.cls = 4'd0;
        for (int k = 1; k < NC; k++) begin
            if (lg[k] > best) begin
                best  = lg[k];
                e.cls = 4'(k);
            end
        end
        e.mx = best;
        return e;
    endfunction

    task automatic scramble_inputs();
        bus.logits_i = {NC{$urandom()}};
    endtask

    task automatic send_frame();
        bus.logits_i = pack_lg();
        bus.valid_i  = 1'b1;
        sb.push_back(model());
        step();
        bus.valid_i = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int k = 0;
        while (bus.valid_o !== 1'b1 && k < 40) begin
            step();
            k++;
            if (k == 1) chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    endtask

    task automatic hold(input string tag, input int n);
        logic [3:0]  c0;
        logic [31:0] m0;
        c0 = bus.class_o;
        m0 = bus.max_o;
        bus.ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(bus.valid_o), 32'd1);
            chk({tag, "_hold_class"}, 32'(bus.class_o), 32'(c0));
            chk({tag, "_hold_max"}, bus.max_o, m0);
        end
        chk({tag, "_hold_cnt"}, 32'(bus.img_cnt_o), 32'(exp_cnt));
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_class"}, 32'(bus.class_o), 32'(e.cls));
            chk({tag, "_max"}, bus.max_o, e.mx);
            $display("frame %s: class=%0d max=%0d", tag, bus.class_o, $signed(bus.max_o));
        end
    endtask

    task automatic do_handshake(input string tag, input bit with_frame);
        bus.ready_i = 1'b1;
        if (with_frame) begin
            bus.logits_i = pack_lg();
            bus.valid_i  = 1'b1;
            sb.push_back(model());
        end
        step();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b0;
        scramble_inputs();
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_valid_drop"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_img_cnt"}, 32'(bus.img_cnt_o), 32'(exp_cnt));
        chk({tag, "_drop"}, 32'(bus.drop_o), 32'(exp_drop));
        if (with_frame) chk({tag, "_b2b_busy"}, 32'(bus.busy_o), 32'd1);
    endtask

    task automatic full_result(input string tag, input int n_hold);
        wait_valid(tag, 10);
        hold(tag, n_hold);
        pop_compare(tag);
        do_handshake(tag, 1'b0);
    endtask

    task automatic random_lg();
        for (int k = 0; k < NC; k++) begin
            if ($urandom_range(0, 3) == 0) lg[k] = $urandom();
            else lg[k] = $signed($urandom_range(0, 6)) - 32'sd3;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_class"}, 32'(bus.class_o), 32'd0);
        chk({tag, "_max"}, bus.max_o, 32'd0);
        chk({tag, "_cnt"}, 32'(bus.img_cnt_o), 32'd0);
        chk({tag, "_drop"}, 32'(bus.drop_o), 32'd0);
    endtask

    initial begin
        bit b2b;
        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b0;
        bus.logits_i = '0;

        step();
        step();
        check_all_zero("reset");
        rst_i = 1'b0;
        step();

        // single frame
        foreach (lg[k]) lg[k] = 32'sd0;
        lg[0] = -32'sd5; lg[1] = 32'sd3; lg[2] = 32'sd100; lg[3] = 32'sd7;
        send_frame();
        full_result("single", 0);

        // ties and extremes
        foreach (lg[k]) lg[k] = -32'sd20;
        send_frame();
        full_result("all_neg", 0);
        foreach (lg[k]) lg[k] = 32'sh8000_0000;
        lg[4] = 32'sh7FFF_FFFF; lg[7] = 32'sh7FFF_FFFF;
        send_frame();
        full_result("tie_max", 1);

        // backpressure
        foreach (lg[k]) lg[k] = 32'(k * 3);
        lg[6] = 32'sd1000;
        send_frame();
        full_result("backpressure", 25);

        // valid_i during SCAN is dropped
        foreach (lg[k]) lg[k] = -32'sd100 + 32'(k);
        send_frame();
        step(); step(); step();
        foreach (lg[k]) lg[k] = 32'sd5000;
        bus.logits_i = pack_lg();
        bus.valid_i  = 1'b1;
        step();
        bus.valid_i = 1'b0;
        exp_drop = 1'b1;
        chk("drop_scan", 32'(bus.drop_o), 32'd1);
        wait_valid("drop", 6);
        hold("drop", 2);
        pop_compare("drop");

        // back-to-back capture on the handshake edge
        foreach (lg[k]) lg[k] = 32'sd9 - 32'(k);
        do_handshake("b2b_first", 1'b1);
        full_result("b2b_second", 0);

        // reset in the middle of a scan
        foreach (lg[k]) lg[k] = 32'(k);
        send_frame();
        step(); step(); step(); step();
        rst_i = 1'b1;
        #1;
        check_all_zero("midscan_rst");
        sb.delete();
        exp_cnt  = 16'd0;
        exp_drop = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        foreach (lg[k]) lg[k] = 32'sd50 - 32'(k * k);
        lg[8] = 32'sd77;
        send_frame();
        full_result("after_rst", 0);

        // randomized sequence with occasional back-to-back frames
        random_lg();
        send_frame();
        for (int i = 0; i < 24; i++) begin
            wait_valid("rand", 10);
            hold("rand", $urandom_range(0, 3));
            pop_compare("rand");
            b2b = (i < 23) && ($urandom_range(0, 1) == 1);
            random_lg();
            if (b2b) begin
                do_handshake("rand_b2b", 1'b1);
            end else begin
                do_handshake("rand", 1'b0);
                if (i < 23) send_frame();
            end
        end
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
